noise_lrelu_stage: RTL

//  Post-convolution activation stage, directly downstream of the conv engine's 64-bit master stream.
//  Per pixel: add scaled per-channel noise (StyleGAN noise injection), apply LeakyReLU,

---
 rtl/noise_lrelu_stage_pkg.sv | 35 +++
 rtl/lfsr_noise_gen.sv | 30 +++
 rtl/noise_lrelu_stage.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/noise_lrelu_stage_pkg.sv
// Shared constants, FSM encoding and saturation helper
// for the noise-injection / LeakyReLU activation stage.
package noise_lrelu_stage_pkg;

   localparam int ACC_W       = 48;
   localparam int ACC_FRAC    = 16;
   localparam int OUT_FRAC    = 8;
   localparam int OUT_W       = 16;
   localparam int LRELU_MUL   = 13;
   localparam int LRELU_SHIFT = 6;
   localparam int NOISE_SHIFT = 7;
   localparam int RQ_SHIFT    = ACC_FRAC - OUT_FRAC;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WLOAD = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   function automatic logic [OUT_W-1:0] sat16(
      input logic signed [ACC_W:0] v
   );
      if (v > 49'sd32767)
         return 16'h7FFF;
      else if (v < -49'sd32768)
         return 16'h8000;
      else
         return v[OUT_W-1:0];
   endfunction

endpackage

// File: rtl/lfsr_noise_gen.sv
// 16-bit Galois LFSR noise source; reload on i_load,
// one step per i_adv.
module lfsr_noise_gen
   import noise_lrelu_stage_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_SEED,
   parameter logic [15:0] TAPS = LFSR_TAPS
) (
   input  logic        clk,
   input  logic        aresetn,
   input  logic        i_load,
   input  logic        i_adv,
   output logic [15:0] o_state
);

   logic [15:0] r_state;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)
         r_state <= SEED;
      else if (i_load)
         r_state <= SEED;
      else if (i_adv)
         r_state <= r_state[0] ? ((r_state >> 1) ^ TAPS)
                               : (r_state >> 1);
   end

   assign o_state = r_state;

endmodule

// File: rtl/noise_lrelu_stage.sv
// Post-conv activation: noise add, LeakyReLU, Q.16 -> Q8.8
// requant, 3-stage pipeline under a single global stall.
module noise_lrelu_stage
   import noise_lrelu_stage_pkg::*;
(
   input  logic        clk,
   input  logic        aresetn,
   input  logic        start,
   input  logic [7:0]  Image_size,
   input  logic [8:0]  Channel_size,
   input  logic        noise_en,
   output logic [8:0]  noise_weight_addr,
   output logic        noise_weight_en,
   input  logic [15:0] noise_weight_douta,
   input  logic [63:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   output logic [15:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        busy,
   output logic        tlast_err
);

   localparam logic signed [52:0] LRELU_K = 53'(LRELU_MUL);
   localparam logic signed [48:0] RQ_RND  = 49'(1 << (RQ_SHIFT - 1));

   state_t r_state;
   logic [13:0] r_pix;
   logic [13:0] r_npix_m1;
   logic [8:0]  r_ch;
   logic [8:0]  r_nch_m1;
   logic        r_noise_en;
   logic        r_run1;
   logic        r_tlast_err;
   logic signed [15:0] r_weight;

   logic               r_v1, r_v2, r_v3;
   logic               r_last1, r_last2, r_last3;
   logic signed [47:0] r_acc1;
   logic signed [31:0] r_prod1;
   logic signed [47:0] r_y2;
   logic [15:0]        r_dat3;

   logic [15:0] w_lfsr;
   logic        w_adv;
   logic        w_fire;
   logic        w_pix_last;
   logic        w_ch_last;
   logic        w_last;
   logic        w_drained;

   logic signed [15:0] w_noise;
   logic signed [15:0] w_wt;
   logic signed [31:0] w_n32;
   logic signed [31:0] w_w32;
   logic signed [31:0] w_prod;
   logic signed [47:0] w_term;
   logic signed [47:0] w_sum;
   logic signed [52:0] w_sum_x;
   logic signed [52:0] w_slope;
   logic signed [52:0] w_leak;
   logic signed [47:0] w_y;
   logic signed [48:0] w_rnd;
   logic signed [48:0] w_rq;
   logic               w_unused;

   lfsr_noise_gen u_lfsr (
      .clk     (clk),
      .aresetn (aresetn),
      .i_load  ((r_state == IDLE) & start),
      .i_adv   (w_fire),
      .o_state (w_lfsr)
   );

   assign w_adv         = !r_v3 | m_axis_tready;
   assign s_axis_tready = (r_state == RUN) & w_adv;
   assign w_fire        = s_axis_tvalid & s_axis_tready;
   assign w_pix_last    = (r_pix == r_npix_m1);
   assign w_ch_last     = (r_ch == r_nch_m1);
   assign w_last        = w_pix_last & w_ch_last;
   assign w_drained     = !r_v1 & !r_v2 & (!r_v3 | m_axis_tready);

   // BRAM data is only valid in the first RUN cycle; use it
   // directly then, and the latched copy afterwards.
   assign w_noise = $signed(w_lfsr);
   assign w_wt    = r_run1 ? $signed(noise_weight_douta) : r_weight;
   assign w_n32   = 32'(w_noise);
   assign w_w32   = 32'(w_wt);
   assign w_prod  = w_n32 * w_w32;

   assign w_term  = {{23{r_prod1[31]}}, r_prod1[31:NOISE_SHIFT]};
   assign w_sum   = r_acc1 + w_term;
   assign w_sum_x = {{5{w_sum[47]}}, w_sum};
   assign w_slope = w_sum_x * LRELU_K;
   assign w_leak  = w_slope >>> LRELU_SHIFT;
   assign w_y     = w_sum[47] ? w_leak[47:0] : w_sum;

   assign w_rnd = {r_y2[47], r_y2} + RQ_RND;
   assign w_rq  = w_rnd >>> RQ_SHIFT;

   assign w_unused = ^{s_axis_tdata[63:48],
                       r_prod1[NOISE_SHIFT-1:0],
                       w_leak[52:48]};

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_state     <= IDLE;
         r_pix       <= '0;
         r_npix_m1   <= '0;
         r_ch        <= '0;
         r_nch_m1    <= '0;
         r_noise_en  <= 1'b0;
         r_run1      <= 1'b0;
         r_tlast_err <= 1'b0;
         r_weight    <= '0;
      end else begin
         r_run1 <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_npix_m1   <= 14'(16'(Image_size) * 16'(Image_size)
                                     - 16'd1);
                  r_nch_m1    <= Channel_size - 9'd1;
                  r_noise_en  <= noise_en;
                  r_pix       <= '0;
                  r_ch        <= '0;
                  r_tlast_err <= 1'b0;
                  r_state     <= WLOAD;
               end
            end
            WLOAD: begin
               r_run1  <= 1'b1;
               r_state <= RUN;
            end
            RUN: begin
               if (r_run1)
                  r_weight <= $signed(noise_weight_douta);
               if (w_fire) begin
                  if (s_axis_tlast != w_last)
                     r_tlast_err <= 1'b1;
                  if (w_pix_last) begin
                     r_pix <= '0;
                     if (w_ch_last) begin
                        r_state <= DRAIN;
                     end else begin
                        r_ch    <= r_ch + 9'd1;
                        r_state <= WLOAD;
                     end
                  end else begin
                     r_pix <= r_pix + 14'd1;
                  end
               end
            end
            DRAIN: begin
               if (w_drained)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_v3    <= 1'b0;
         r_last1 <= 1'b0;
         r_last2 <= 1'b0;
         r_last3 <= 1'b0;
         r_acc1  <= '0;
         r_prod1 <= '0;
         r_y2    <= '0;
         r_dat3  <= '0;
      end else if (w_adv) begin
         r_v1    <= w_fire;
         r_last1 <= w_fire & w_last;
         if (w_fire) begin
            r_acc1  <= $signed(s_axis_tdata[47:0]);
            r_prod1 <= r_noise_en ? w_prod : '0;
         end
         r_v2    <= r_v1;
         r_last2 <= r_v1 & r_last1;
         if (r_v1)
            r_y2 <= w_y;
         r_v3    <= r_v2;
         r_last3 <= r_v2 & r_last2;
         if (r_v2)
            r_dat3 <= sat16(w_rq);
      end
   end

   assign m_axis_tdata      = r_dat3;
   assign m_axis_tvalid     = r_v3;
   assign m_axis_tlast      = r_last3;
   assign busy              = (r_state != IDLE);
   assign tlast_err         = r_tlast_err;
   assign noise_weight_en   = (r_state == WLOAD);
   assign noise_weight_addr = r_ch;

endmodule
